// File: rtl/raizing_tileline_render_if.sv
// raizing_tileline_render_if: video timing, pixel output and memory read ports of the tileline renderer.
interface raizing_tileline_render_if #(parameter int VA_W = 11);
   logic             PIXEL_CEN, HB, VB, ACTIVE, FLIPX, FLIPY;
   logic [8:0]       VRENDER, H;
   logic [10:0]      PIXEL;
   logic             BUSY, OVERRUN;
   logic [7:0]       SEL_ADDR, SCR_ADDR;
   logic [VA_W-1:0]  VRAM_ADDR;
   logic [13:0]      ROM_ADDR;
   logic [15:0]      SEL_DATA, SCR_DATA, VRAM_DATA, ROM_DATA;
   modport master (
      output PIXEL_CEN, HB, VB, ACTIVE, FLIPX, FLIPY, VRENDER, H,
             SEL_DATA, SCR_DATA, VRAM_DATA, ROM_DATA,
      input  PIXEL, BUSY, OVERRUN, SEL_ADDR, SCR_ADDR, VRAM_ADDR, ROM_ADDR
   );
   modport slave (
      input  PIXEL_CEN, HB, VB, ACTIVE, FLIPX, FLIPY, VRENDER, H,
             SEL_DATA, SCR_DATA, VRAM_DATA, ROM_DATA,
      output PIXEL, BUSY, OVERRUN, SEL_ADDR, SCR_ADDR, VRAM_ADDR, ROM_ADDR
   );
endinterface

// File: rtl/raizing_tileline_render.sv
// raizing_tileline_render: per-line scrolling tilemap renderer into a ping-pong line buffer,
// replaying the previous line to the mixer indexed by H.
module raizing_tileline_render #(
   parameter int          TILES       = 41,
   parameter int          PIX_W       = 320,
   parameter int          COLS_LOG2   = 6,
   parameter int          ROWS_LOG2   = 5,
   parameter logic [15:0] SCROLL_OFFS = 16'h2C,
   parameter logic [10:0] PAL_BASE    = 11'h400,
   parameter int          RD_LAT      = 2
) (
   input logic CLK96,
   input logic RESET96,
   raizing_tileline_render_if.slave bus
);
   localparam int XW = $clog2(TILES + 1);
   localparam int PB = XW + 4;
   localparam int AW = $clog2(PIX_W);
   localparam int VW = ROWS_LOG2 + COLS_LOG2;
   typedef enum logic [3:0] {
      S_IDLE, S_LINE_RD, S_WAIT, S_LINE_CALC, S_TILE_VRAM, S_ROM0, S_ROM1, S_ROM2, S_DRAW, S_NEXT
   } state_t;
   state_t                 state_q, state_d, ret_q, ret_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [XW-1:0]          x_q, x_d;
   logic [2:0]             tx_q, tx_d, fine_q, fine_d, ty_q, ty_d;
   logic [COLS_LOG2-1:0]   startx_q, startx_d;
   logic [ROWS_LOG2-1:0]   row_q, row_d;
   logic [5:0]             pal_q, pal_d;
   logic [15:0]            hi_q, hi_d, lo_q, lo_d;
   logic [7:0]             sel_addr_q, sel_addr_d;
   logic [VW-1:0]          vram_addr_q, vram_addr_d;
   logic [13:0]            rom_addr_q, rom_addr_d;
   logic                   flipx_q, flipy_q, bank_q, hb_q, ovr_q;
   logic [10:0]            pix_q;
   logic [10:0]            lb_q [2][PIX_W];
   logic                   line_start, wr_en, unused_bits;
   logic [15:0]            off;
   logic [31:0]            word;
   logic signed [PB-1:0]   pos;
   logic [3:0]             nib;
   logic [AW-1:0]          wr_addr;
   logic [10:0]            wr_data;
   assign line_start  = hb_q & ~bus.HB & ~bus.VB;
   assign off         = bus.SCR_DATA + SCROLL_OFFS;
   assign word        = {hi_q, lo_q};
   assign nib         = 4'(word >> (5'd28 - {tx_q, 2'b00}));
   assign pos         = $signed({1'b0, x_q, tx_q}) - $signed({{(XW + 1){1'b0}}, fine_q});
   assign wr_en       = state_q == S_DRAW && !line_start && !pos[PB-1] && pos[PB-2:0] < (PB - 1)'(PIX_W);
   assign wr_addr     = flipx_q ? AW'(PIX_W - 1) - pos[AW-1:0] : pos[AW-1:0];
   assign wr_data     = nib != 4'd0 ? PAL_BASE + {1'b0, pal_q, nib} : 11'd0;
   assign unused_bits = ^{bus.VRENDER[8], bus.SEL_DATA[15:ROWS_LOG2+3], off[15:COLS_LOG2+3]};
   assign bus.PIXEL     = pix_q;
   assign bus.BUSY      = state_q != S_IDLE;
   assign bus.OVERRUN   = ovr_q;
   assign bus.SEL_ADDR  = sel_addr_q;
   assign bus.SCR_ADDR  = sel_addr_q;
   assign bus.VRAM_ADDR = vram_addr_q;
   assign bus.ROM_ADDR  = rom_addr_q;
   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      cnt_d       = '0;
      x_d         = x_q;
      tx_d        = tx_q;
      fine_d      = fine_q;
      ty_d        = ty_q;
      startx_d    = startx_q;
      row_d       = row_q;
      pal_d       = pal_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      sel_addr_d  = sel_addr_q;
      vram_addr_d = vram_addr_q;
      rom_addr_d  = rom_addr_q;
      if (line_start) begin
         state_d = S_LINE_RD;
         x_d     = '0;
      end else begin
         case (state_q)
            S_LINE_RD: begin
               sel_addr_d = flipy_q ? ~bus.VRENDER[7:0] : bus.VRENDER[7:0];
               state_d    = S_WAIT;
               ret_d      = S_LINE_CALC;
            end
            S_WAIT: begin
               cnt_d   = cnt_q + 2'd1;
               state_d = cnt_q == 2'(RD_LAT - 1) ? ret_q : S_WAIT;
            end
            S_LINE_CALC: begin
               startx_d = off[COLS_LOG2+2:3];
               fine_d   = off[2:0];
               row_d    = bus.SEL_DATA[ROWS_LOG2+2:3];
               ty_d     = bus.SEL_DATA[2:0];
               state_d  = S_TILE_VRAM;
            end
            S_TILE_VRAM: begin
               vram_addr_d = {row_q, startx_q + COLS_LOG2'(x_q)};
               state_d     = S_WAIT;
               ret_d       = S_ROM0;
            end
            S_ROM0: begin
               pal_d      = bus.VRAM_DATA[15:10];
               rom_addr_d = {bus.VRAM_DATA[9:0], ty_q, 1'b0};
               state_d    = S_WAIT;
               ret_d      = S_ROM1;
            end
            // even word is the left half of the row, odd word the right half
            S_ROM1: begin
               hi_d       = bus.ROM_DATA;
               rom_addr_d = rom_addr_q | 14'd1;
               state_d    = S_WAIT;
               ret_d      = S_ROM2;
            end
            S_ROM2: begin
               lo_d    = bus.ROM_DATA;
               tx_d    = '0;
               state_d = S_DRAW;
            end
            S_DRAW: begin
               tx_d    = tx_q + 3'd1;
               state_d = tx_q == 3'd7 ? S_NEXT : S_DRAW;
            end
            S_NEXT: begin
               x_d     = x_q + 1'b1;
               state_d = x_q + 1'b1 == XW'(TILES) ? S_IDLE : S_TILE_VRAM;
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge CLK96) begin
      if (RESET96) begin
         state_q     <= S_IDLE;
         ret_q       <= S_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         tx_q        <= '0;
         fine_q      <= '0;
         ty_q        <= '0;
         startx_q    <= '0;
         row_q       <= '0;
         pal_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         sel_addr_q  <= '0;
         vram_addr_q <= '0;
         rom_addr_q  <= '0;
         flipx_q     <= 1'b0;
         flipy_q     <= 1'b0;
         bank_q      <= 1'b0;
         hb_q        <= 1'b0;
         ovr_q       <= 1'b0;
         pix_q       <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         tx_q        <= tx_d;
         fine_q      <= fine_d;
         ty_q        <= ty_d;
         startx_q    <= startx_d;
         row_q       <= row_d;
         pal_q       <= pal_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         sel_addr_q  <= sel_addr_d;
         vram_addr_q <= vram_addr_d;
         rom_addr_q  <= rom_addr_d;
         hb_q        <= bus.HB;
         ovr_q       <= line_start && state_q != S_IDLE;
         if (line_start) begin
            bank_q  <= ~bank_q;
            flipx_q <= bus.FLIPX;
            flipy_q <= bus.FLIPY;
         end
         if (bus.PIXEL_CEN && bus.ACTIVE)
            pix_q <= bus.H < 9'(PIX_W) ? lb_q[~bank_q][bus.H[AW-1:0]] : 11'd0;
      end
   end
   always_ff @(posedge CLK96)
      if (wr_en) lb_q[bank_q][wr_addr] <= wr_data;
endmodule
